usb_cmd_rx: RTL and testbench

- Host-to-board command path for the CIS driver: the read side of the FT232H-style synchronous FIFO whose write side streams ADC pixel data to the host.
- Pulls command bytes from the USB IC (USB_RXF_L / USB_OE_L / USB_RD_L handshake) and assembles them into fixed-length packets.
- Decodes each packet and updates the configuration registers that drive the CIS timing generator, LEDs and streaming enable.
- Arbitrates with the pixel writer so the shared USB data bus is never driven by both directions at once.

---
 rtl/usb_cmd_rx.sv | 219 +++++++++++++++++++++
 tb/tb_usb_cmd_rx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_rx.sv
// Read side of an FT232H-style synchronous FIFO: pulls host command bytes, assembles packets, updates config registers.
// Optional build macro CMD_CHECKSUM_EN: 4-byte packets whose last byte is the XOR of opcode, data_hi and data_lo.
module usb_cmd_rx #(
   parameter logic [15:0] DEFAULT_EXPOSURE = 16'd1000,
   parameter int          MAX_BURST        = 64,
   parameter int          TIMEOUT_CYCLES   = 6000
) (
   input  logic        USB_CLK,
   input  logic        RESET,
   input  logic        USB_RXF_L,
   input  logic [7:0]  USB_DATA_IN,
   input  logic        TX_ACTIVE,
   output logic        USB_OE_L,
   output logic        USB_RD_L,
   output logic        RX_ACTIVE,
   output logic [15:0] EXPOSURE,
   output logic [2:0]  LED_MASK,
   output logic        CIS_MODE_CFG,
   output logic        STREAM_EN,
   output logic        CMD_STROBE,
   output logic [7:0]  CMD_OPCODE,
   output logic [7:0]  ERR_COUNT
);
`ifdef CMD_CHECKSUM_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif
   localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       BURST_LAST = 8'(MAX_BURST - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_TURN = 2'd1, S_READ = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             oe_l_q, oe_l_d, rd_l_q, rd_l_d, rx_act_q, rx_act_d;
   logic [7:0]       burst_q, burst_d;
   logic             accept_s;
   logic [1:0]       idx_q;
   logic [7:0]       op_q, hi_q;
`ifdef CMD_CHECKSUM_EN
   logic [7:0]       lo_q;
`endif
   logic [TMO_W-1:0] tmo_q;
   logic             pend_ok_q, pend_err_q, tmo_err_q;
   logic [7:0]       pend_op_q;
   logic [15:0]      pend_data_q;
   logic [7:0]       fin_lo_s;
   logic             fin_ok_s;
   logic [15:0]      exposure_q;
   logic [2:0]       led_q;
   logic             mode_q, stream_q, strobe_q;
   logic [7:0]       opcode_q, err_q;

`ifdef CMD_CHECKSUM_EN
   function automatic logic [7:0] pkt_csum(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo);
      return op ^ hi ^ lo;
   endfunction
`endif

   function automatic logic opcode_ok(input logic [7:0] op, input logic [15:0] data);
      case (op)
         8'h00, 8'h02, 8'h03, 8'h04: opcode_ok = 1'b1;
         8'h01:                      opcode_ok = (data != 16'd0);
         default:                    opcode_ok = 1'b0;
      endcase
   endfunction

   // RD_L is only low in READ, so this is exactly a byte handed over by the USB IC
   assign accept_s = (state_q == S_READ) && !rd_l_q && !USB_RXF_L;

   // Bus-side state and registered handshake outputs
   always_ff @(posedge USB_CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         oe_l_q   <= 1'b1;
         rd_l_q   <= 1'b1;
         rx_act_q <= 1'b0;
         burst_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         oe_l_q   <= oe_l_d;
         rd_l_q   <= rd_l_d;
         rx_act_q <= rx_act_d;
         burst_q  <= burst_d;
      end
   end

   // Next-state: the writer has priority in IDLE; a burst ends on empty FIFO or the burst cap
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!USB_RXF_L && !TX_ACTIVE) state_d = S_TURN;
            else                          state_d = S_IDLE;
         end
         S_TURN: state_d = S_READ;
         S_READ: begin
            if (USB_RXF_L || (burst_q == BURST_LAST)) state_d = S_IDLE;
            else                                      state_d = S_READ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs follow the state being entered so they change on the same edge
   always_comb begin
      oe_l_d   = (state_d == S_IDLE);
      rx_act_d = (state_d != S_IDLE);
      rd_l_d   = (state_d != S_READ);
      if ((state_q == S_READ) && (state_d == S_READ)) begin
         if (accept_s) burst_d = burst_q + 8'd1;
         else          burst_d = burst_q;
      end else begin
         burst_d = 8'd0;
      end
   end

   // Final-byte view of the packet being completed this edge
   always_comb begin
`ifdef CMD_CHECKSUM_EN
      fin_lo_s = lo_q;
      fin_ok_s = opcode_ok(op_q, {hi_q, lo_q}) && (USB_DATA_IN == pkt_csum(op_q, hi_q, lo_q));
`else
      fin_lo_s = USB_DATA_IN;
      fin_ok_s = opcode_ok(op_q, {hi_q, USB_DATA_IN});
`endif
   end

   // Packet assembly and inter-byte timeout; a byte on the timeout edge continues the packet
   always_ff @(posedge USB_CLK) begin
      if (RESET) begin
         idx_q       <= 2'd0;
         op_q        <= 8'd0;
         hi_q        <= 8'd0;
`ifdef CMD_CHECKSUM_EN
         lo_q        <= 8'd0;
`endif
         tmo_q       <= '0;
         pend_ok_q   <= 1'b0;
         pend_err_q  <= 1'b0;
         tmo_err_q   <= 1'b0;
         pend_op_q   <= 8'd0;
         pend_data_q <= 16'd0;
      end else begin
         pend_ok_q  <= 1'b0;
         pend_err_q <= 1'b0;
         tmo_err_q  <= 1'b0;
         if (accept_s) begin
            tmo_q <= '0;
            case (idx_q)
               2'd0:    op_q <= USB_DATA_IN;
               2'd1:    hi_q <= USB_DATA_IN;
`ifdef CMD_CHECKSUM_EN
               2'd2:    lo_q <= USB_DATA_IN;
`endif
               default: op_q <= op_q;
            endcase
            if (idx_q == LAST_IDX) begin
               idx_q       <= 2'd0;
               pend_ok_q   <= fin_ok_s;
               pend_err_q  <= !fin_ok_s;
               pend_op_q   <= op_q;
               pend_data_q <= {hi_q, fin_lo_s};
            end else begin
               idx_q <= idx_q + 2'd1;
            end
         end else if (idx_q != 2'd0) begin
            if (tmo_q == TMO_LAST) begin
               idx_q     <= 2'd0;
               tmo_q     <= '0;
               tmo_err_q <= 1'b1;
            end else begin
               tmo_q <= tmo_q + TMO_W'(1);
            end
         end else begin
            tmo_q <= '0;
         end
      end
   end

   // Commit stage: configuration registers, strobe and saturating error count
   always_ff @(posedge USB_CLK) begin
      if (RESET) begin
         exposure_q <= DEFAULT_EXPOSURE;
         led_q      <= 3'd0;
         mode_q     <= 1'b0;
         stream_q   <= 1'b0;
         strobe_q   <= 1'b0;
         opcode_q   <= 8'd0;
         err_q      <= 8'd0;
      end else begin
         strobe_q <= pend_ok_q;
         if (pend_ok_q) begin
            opcode_q <= pend_op_q;
            case (pend_op_q)
               8'h01:   exposure_q <= pend_data_q;
               8'h02:   led_q      <= pend_data_q[2:0];
               8'h03:   mode_q     <= pend_data_q[0];
               8'h04:   stream_q   <= pend_data_q[0];
               default: led_q      <= led_q;
            endcase
         end
         if ((pend_err_q || tmo_err_q) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
   end

   assign USB_OE_L     = oe_l_q;
   assign USB_RD_L     = rd_l_q;
   assign RX_ACTIVE    = rx_act_q;
   assign EXPOSURE     = exposure_q;
   assign LED_MASK     = led_q;
   assign CIS_MODE_CFG = mode_q;
   assign STREAM_EN    = stream_q;
   assign CMD_STROBE   = strobe_q;
   assign CMD_OPCODE   = opcode_q;
   assign ERR_COUNT    = err_q;

endmodule

// File: tb/tb_usb_cmd_rx.sv
// Self-checking bench for usb_cmd_rx: host FIFO model, packet-level reference model, directed and random scenarios.
module tb_usb_cmd_rx;
`ifdef CMD_CHECKSUM_EN
   localparam int PKT_LEN = 4;
`else
   localparam int PKT_LEN = 3;
`endif
   localparam int MAX_BURST      = 64;
   localparam int TIMEOUT_CYCLES = 6000;

   logic        USB_CLK     = 1'b0;
   logic        RESET       = 1'b1;
   logic        USB_RXF_L   = 1'b1;
   logic [7:0]  USB_DATA_IN = 8'h00;
   logic        TX_ACTIVE   = 1'b0;
   logic        USB_OE_L, USB_RD_L, RX_ACTIVE, CIS_MODE_CFG, STREAM_EN, CMD_STROBE;
   logic [15:0] EXPOSURE;
   logic [2:0]  LED_MASK;
   logic [7:0]  CMD_OPCODE, ERR_COUNT;

   usb_cmd_rx #(
      .DEFAULT_EXPOSURE(16'd1000),
      .MAX_BURST(MAX_BURST),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .USB_CLK(USB_CLK), .RESET(RESET), .USB_RXF_L(USB_RXF_L), .USB_DATA_IN(USB_DATA_IN),
      .TX_ACTIVE(TX_ACTIVE), .USB_OE_L(USB_OE_L), .USB_RD_L(USB_RD_L), .RX_ACTIVE(RX_ACTIVE),
      .EXPOSURE(EXPOSURE), .LED_MASK(LED_MASK), .CIS_MODE_CFG(CIS_MODE_CFG), .STREAM_EN(STREAM_EN),
      .CMD_STROBE(CMD_STROBE), .CMD_OPCODE(CMD_OPCODE), .ERR_COUNT(ERR_COUNT)
   );

   always #5 USB_CLK = ~USB_CLK;

   int         checks = 0, errors = 0, cyc = 0;
   logic [7:0] hostq[$];
   logic       hold_rxf = 1'b0;
   int         run_len = 0, max_run = 0, n_bursts = 0, obs_strobes = 0;

   // Reference model: packet-level view of the command stream
   logic [7:0]  m_buf [4];
   int          m_idx = 0, m_idle = 0, m_err = 0, m_strobes = 0;
   logic [15:0] m_exp = 16'd1000;
   logic [2:0]  m_led = 3'd0;
   logic        m_mode = 1'b0, m_stream = 1'b0;
   logic [7:0]  m_op = 8'd0;

   task automatic model_reset();
      m_idx = 0; m_idle = 0; m_err = 0; m_strobes = 0; obs_strobes = 0;
      m_exp = 16'd1000; m_led = 3'd0; m_mode = 1'b0; m_stream = 1'b0; m_op = 8'd0;
   endtask

   task automatic model_err();
      if (m_err < 255) m_err++;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [15:0] data;
      logic        ok;
      m_buf[m_idx] = b;
      m_idx++;
      m_idle = 0;
      if (m_idx == PKT_LEN) begin
         m_idx = 0;
         data  = {m_buf[1], m_buf[2]};
         case (m_buf[0])
            8'h00, 8'h02, 8'h03, 8'h04: ok = 1'b1;
            8'h01:                      ok = (data != 16'd0);
            default:                    ok = 1'b0;
         endcase
         if (PKT_LEN == 4 && m_buf[3] != (m_buf[0] ^ m_buf[1] ^ m_buf[2])) ok = 1'b0;
         if (ok) begin
            m_strobes++;
            m_op = m_buf[0];
            case (m_buf[0])
               8'h01:   m_exp    = data;
               8'h02:   m_led    = data[2:0];
               8'h03:   m_mode   = data[0];
               8'h04:   m_stream = data[0];
               default: m_op     = m_buf[0];
            endcase
         end else begin
            model_err();
         end
      end
   endtask

   task automatic model_idle();
      if (m_idx != 0) begin
         m_idle++;
         if (m_idle == TIMEOUT_CYCLES) begin
            m_idx  = 0;
            m_idle = 0;
            model_err();
         end
      end
   endtask

   task automatic drive_host();
      USB_RXF_L   = (hostq.size() == 0) || hold_rxf;
      USB_DATA_IN = (hostq.size() != 0) ? hostq[0] : 8'($urandom);
   endtask

   // One clock: present host data, advance the model, check bus-ownership invariants
   task automatic step();
      logic acc, tx_at_edge, rx_before;
      drive_host();
      acc        = !RESET && (USB_RD_L === 1'b0) && !USB_RXF_L;
      tx_at_edge = TX_ACTIVE;
      rx_before  = RX_ACTIVE;
      @(posedge USB_CLK);
      #1;
      cyc++;
      if (RESET)    model_reset();
      else if (acc) model_byte(hostq.pop_front());
      else          model_idle();
      if (acc) run_len++;
      if (USB_RD_L && run_len > 0) begin
         n_bursts++;
         if (run_len > max_run) max_run = run_len;
         run_len = 0;
      end
      if (CMD_STROBE) obs_strobes++;
      checks++;
      if ((USB_OE_L !== !RX_ACTIVE) || (!USB_RD_L && USB_OE_L)) begin
         errors++;
         $display("FAIL bus_owner cyc %0d: OE_L=%b RD_L=%b RX_ACTIVE=%b, required OE_L=!RX_ACTIVE and RD_L low only with OE_L low",
                  cyc, USB_OE_L, USB_RD_L, RX_ACTIVE);
      end
      if (!rx_before && RX_ACTIVE) begin
         checks++;
         if (tx_at_edge !== 1'b0) begin
            errors++;
            $display("FAIL rx_start_while_tx cyc %0d: TX_ACTIVE=%b at start, required 0", cyc, tx_at_edge);
         end
      end
   endtask

   task automatic push_cmd(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo, input logic bad);
      hostq.push_back(op);
      hostq.push_back(hi);
      hostq.push_back(lo);
`ifdef CMD_CHECKSUM_EN
      hostq.push_back(op ^ hi ^ lo ^ (bad ? 8'h5A : 8'h00));
`else
      if (bad) hostq.push_back(8'h00);
`endif
   endtask

   task automatic drain(input int bound);
      int n = 0;
      hold_rxf  = 1'b0;
      TX_ACTIVE = 1'b0;
      while (hostq.size() != 0 && n < bound) begin
         step();
         n++;
      end
      checks++;
      if (hostq.size() != 0) begin
         errors++;
         $display("FAIL drain_bound: %0d bytes left after %0d cycles, required 0", hostq.size(), bound);
         hostq.delete();
      end
      repeat (4) step();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (2) step();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) step();
      checks += 10;
      if (USB_OE_L !== 1'b1)        begin errors++; $display("FAIL rst_oe_l: got %b expected 1", USB_OE_L); end
      if (USB_RD_L !== 1'b1)        begin errors++; $display("FAIL rst_rd_l: got %b expected 1", USB_RD_L); end
      if (RX_ACTIVE !== 1'b0)       begin errors++; $display("FAIL rst_rx_active: got %b expected 0", RX_ACTIVE); end
      if (EXPOSURE !== 16'd1000)    begin errors++; $display("FAIL rst_exposure: got %0d expected 1000", EXPOSURE); end
      if (LED_MASK !== 3'd0)        begin errors++; $display("FAIL rst_led: got %b expected 000", LED_MASK); end
      if (CIS_MODE_CFG !== 1'b0)    begin errors++; $display("FAIL rst_mode: got %b expected 0", CIS_MODE_CFG); end
      if (STREAM_EN !== 1'b0)       begin errors++; $display("FAIL rst_stream: got %b expected 0", STREAM_EN); end
      if (CMD_STROBE !== 1'b0)      begin errors++; $display("FAIL rst_strobe: got %b expected 0", CMD_STROBE); end
      if (CMD_OPCODE !== 8'h00)     begin errors++; $display("FAIL rst_opcode: got %h expected 00", CMD_OPCODE); end
      if (ERR_COUNT !== 8'd0)       begin errors++; $display("FAIL rst_err: got %0d expected 0", ERR_COUNT); end
      RESET = 1'b0;
      step();
   endtask

   task automatic test_exposure();
      int c0, t_oe = -1, t_rd = -1, t_last = -1, t_strobe = -1, nstrobe = 0;
      logic [15:0] exp_at_strobe = 16'd0;
      logic [7:0]  op_at_strobe = 8'd0;
      push_cmd(8'h01, 8'h0B, 8'hB8, 1'b0);
      c0 = cyc;
      repeat (30) begin
         step();
         if (t_oe < 0 && !USB_OE_L) t_oe = cyc - c0;
         if (t_rd < 0 && !USB_RD_L) t_rd = cyc - c0;
         if (t_last < 0 && hostq.size() == 0) t_last = cyc - c0;
         if (CMD_STROBE) begin
            nstrobe++;
            if (t_strobe < 0) begin
               t_strobe = cyc - c0; exp_at_strobe = EXPOSURE; op_at_strobe = CMD_OPCODE;
            end
         end
      end
      checks += 6;
      if (t_oe != 1)               begin errors++; $display("FAIL exp_oe_fall: got cycle %0d expected 1", t_oe); end
      if (t_rd != t_oe + 1)        begin errors++; $display("FAIL exp_rd_fall: got cycle %0d expected %0d", t_rd, t_oe + 1); end
      if (t_strobe != t_last + 1)  begin errors++; $display("FAIL exp_strobe_latency: got cycle %0d expected %0d", t_strobe, t_last + 1); end
      if (nstrobe != 1)            begin errors++; $display("FAIL exp_strobe_count: got %0d expected 1", nstrobe); end
      if (exp_at_strobe !== 16'd3000) begin errors++; $display("FAIL exp_value: got %0d expected 3000", exp_at_strobe); end
      if (op_at_strobe !== 8'h01)  begin errors++; $display("FAIL exp_opcode: got %h expected 01", op_at_strobe); end
   endtask

   task automatic test_tx_priority();
      int grabbed = 0;
      TX_ACTIVE = 1'b1;
      push_cmd(8'h02, 8'h00, 8'h03, 1'b0);
      repeat (10) begin
         step();
         if (!USB_OE_L || !USB_RD_L || RX_ACTIVE) grabbed++;
      end
      TX_ACTIVE = 1'b0;
      step();
      checks += 3;
      if (grabbed != 0) begin errors++; $display("FAIL tx_hold: bus taken in %0d cycles, expected 0", grabbed); end
      if (USB_OE_L !== 1'b0 || RX_ACTIVE !== 1'b1)
         begin errors++; $display("FAIL tx_release: OE_L=%b RX_ACTIVE=%b expected 0/1", USB_OE_L, RX_ACTIVE); end
      drain(50);
      if (LED_MASK !== 3'b011) begin errors++; $display("FAIL tx_led: got %b expected 011", LED_MASK); end
   endtask

   task automatic test_burst();
      int s0 = obs_strobes;
      int exp_bursts = (66 * PKT_LEN + MAX_BURST - 1) / MAX_BURST;
      max_run = 0; n_bursts = 0;
      repeat (66) push_cmd(8'h02, 8'h00, 8'h05, 1'b0);
      drain(2000);
      checks += 5;
      if (max_run != MAX_BURST)       begin errors++; $display("FAIL burst_cap: got %0d expected %0d", max_run, MAX_BURST); end
      if (n_bursts != exp_bursts)     begin errors++; $display("FAIL burst_count: got %0d expected %0d", n_bursts, exp_bursts); end
      if (LED_MASK !== 3'b101)        begin errors++; $display("FAIL burst_led: got %b expected 101", LED_MASK); end
      if (obs_strobes - s0 != 66)     begin errors++; $display("FAIL burst_strobes: got %0d expected 66", obs_strobes - s0); end
      if (ERR_COUNT !== 8'd0)         begin errors++; $display("FAIL burst_err: got %0d expected 0", ERR_COUNT); end
   endtask

   task automatic test_reject();
      int exp_err = 2;
      do_reset();
      push_cmd(8'h7F, 8'h00, 8'h00, 1'b0);
      push_cmd(8'h01, 8'h00, 8'h00, 1'b0);
`ifdef CMD_CHECKSUM_EN
      push_cmd(8'h04, 8'h00, 8'h01, 1'b1);
      exp_err = 3;
`endif
      drain(100);
      checks += 4;
      if (ERR_COUNT !== 8'(exp_err)) begin errors++; $display("FAIL rej_err: got %0d expected %0d", ERR_COUNT, exp_err); end
      if (EXPOSURE !== 16'd1000)     begin errors++; $display("FAIL rej_exposure: got %0d expected 1000", EXPOSURE); end
      if (obs_strobes != 0)          begin errors++; $display("FAIL rej_strobe: got %0d expected 0", obs_strobes); end
      if (STREAM_EN !== 1'b0)        begin errors++; $display("FAIL rej_stream: got %b expected 0", STREAM_EN); end
   endtask

   task automatic test_timeout();
      do_reset();
      hostq.push_back(8'h04);
      hostq.push_back(8'h00);
      drain(50);
      repeat (5900) step();
      checks += 4;
      if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL tmo_early: got %0d expected 0", ERR_COUNT); end
      repeat (200) step();
      if (ERR_COUNT !== 8'd1) begin errors++; $display("FAIL tmo_fire: got %0d expected 1", ERR_COUNT); end
      push_cmd(8'h04, 8'h00, 8'h01, 1'b0);
      drain(50);
      if (STREAM_EN !== 1'b1) begin errors++; $display("FAIL tmo_stream: got %b expected 1", STREAM_EN); end
      if (ERR_COUNT !== 8'd1) begin errors++; $display("FAIL tmo_err_after: got %0d expected 1", ERR_COUNT); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      push_cmd(8'h01, 8'h12, 8'h34, 1'b0);
      while (m_idx != 1 && n < 20) begin
         step();
         n++;
      end
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      checks += 5;
      if (USB_OE_L !== 1'b1 || USB_RD_L !== 1'b1)
         begin errors++; $display("FAIL rmid_bus: OE_L=%b RD_L=%b expected 1/1", USB_OE_L, USB_RD_L); end
      if (RX_ACTIVE !== 1'b0)    begin errors++; $display("FAIL rmid_rx_active: got %b expected 0", RX_ACTIVE); end
      if (EXPOSURE !== 16'd1000) begin errors++; $display("FAIL rmid_exposure: got %0d expected 1000", EXPOSURE); end
      hostq.delete();
      push_cmd(8'h01, 8'h00, 8'h64, 1'b0);
      drain(50);
      if (EXPOSURE !== 16'd100)  begin errors++; $display("FAIL rmid_reparse: got %0d expected 100", EXPOSURE); end
      if (ERR_COUNT !== 8'd0)    begin errors++; $display("FAIL rmid_err: got %0d expected 0", ERR_COUNT); end
   endtask

   task automatic test_random();
      int n = 0;
      int sel;
      logic [7:0] op, hi, lo;
      do_reset();
      max_run = 0;
      repeat (150) begin
         sel = $urandom_range(0, 9);
         hi  = 8'($urandom);
         lo  = 8'($urandom);
         if (sel <= 4)      op = 8'(sel);
         else if (sel == 5) begin op = 8'h01; hi = 8'h00; lo = 8'h00; end
         else               op = 8'($urandom);
         push_cmd(op, hi, lo, ($urandom_range(0, 7) == 0) && (PKT_LEN == 4));
      end
      while (hostq.size() != 0 && n < 20000) begin
         hold_rxf  = ($urandom_range(0, 4) == 0);
         TX_ACTIVE = ($urandom_range(0, 9) < 3);
         step();
         n++;
      end
      drain(200);
      checks += 8;
      if (EXPOSURE !== m_exp)       begin errors++; $display("FAIL rnd_exposure: got %0d expected %0d", EXPOSURE, m_exp); end
      if (LED_MASK !== m_led)       begin errors++; $display("FAIL rnd_led: got %b expected %b", LED_MASK, m_led); end
      if (CIS_MODE_CFG !== m_mode)  begin errors++; $display("FAIL rnd_mode: got %b expected %b", CIS_MODE_CFG, m_mode); end
      if (STREAM_EN !== m_stream)   begin errors++; $display("FAIL rnd_stream: got %b expected %b", STREAM_EN, m_stream); end
      if (CMD_OPCODE !== m_op)      begin errors++; $display("FAIL rnd_opcode: got %h expected %h", CMD_OPCODE, m_op); end
      if (ERR_COUNT !== 8'(m_err))  begin errors++; $display("FAIL rnd_err: got %0d expected %0d", ERR_COUNT, m_err); end
      if (obs_strobes != m_strobes) begin errors++; $display("FAIL rnd_strobes: got %0d expected %0d", obs_strobes, m_strobes); end
      if (max_run > MAX_BURST)      begin errors++; $display("FAIL rnd_burst_cap: got %0d expected <= %0d", max_run, MAX_BURST); end
   endtask

   initial begin
      test_reset();
      test_exposure();
      test_tx_priority();
      test_burst();
      test_reject();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
